uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter among N_REQ requesters using round-robin arbitration.
- Latches the winning byte and drives the transmitter's start/data inputs. Tracks the transmitter's busy flag through the frame, then reports completion to the owning requester.
- Sits between the system-side byte producers (command, status, debug) and the TX serializer.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT, 1024, max clk cycles to wait for tx_busy to rise after launch (>=2)
ID_W, 2, width of active_id; must be >= clog2(N_REQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low
req  input  N_REQ  per-requester byte-pending request, level
req_data  input  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
grant  output  N_REQ  one-hot 1-cycle pulse: byte accepted/latched
done  output  N_REQ  one-hot 1-cycle pulse: byte fully transmitted
tx_data  output  DATA_W  byte to transmitter (latched copy)
tx_start  output  1  launch request to transmitter, level
tx_busy  input  1  transmitter frame in progress
active_id  output  ID_W  index of current owner (valid when busy_o=1)
busy_o  output  1  arbiter not in IDLE
err_timeout  output  1  1-cycle pulse: transmitter never went busy

Behaviour:
- All outputs registered. Reset (rst=0 at a clock edge): state=IDLE, grant=0, done=0, tx_start=0, tx_data=0, active_id=0, busy_o=0, err_timeout=0, rr_ptr=0, timeout counter=0. A reset mid-frame aborts immediately. No done is issued for the aborted byte.
- States: IDLE, LAUNCH, SEND.
- IDLE: if any req bit is set, select the winner: first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ. On that edge:
  - latch tx_data=req_data[winner] and active_id=winner;
  - grant[winner]=1 for one cycle;
  - tx_start=1, busy_o=1, counter=0;
  - go to LAUNCH.
  - Latency: req sampled high at edge t gives grant and tx_start high after edge t.
- LAUNCH: tx_start held 1.
  - tx_busy=1: tx_start<=0, go to SEND.
  - Else, if counter==TIMEOUT-1: tx_start<=0, err_timeout pulse, rr_ptr<=winner+1 (mod N_REQ), go to IDLE. No done.
  - Else counter increments.
- SEND: wait for tx_busy=0. On that edge: done[active_id]=1 for one cycle, rr_ptr<=active_id+1 (mod N_REQ), busy_o<=0, go to IDLE.
- Arbitration only occurs in IDLE. The minimum spacing between consecutive grants is therefore 3 cycles, even when tx_busy responds instantly.
- Requester handshake:
  - hold req and req_data stable until grant;
  - a grant consumes exactly one byte;
  - req still high on the cycle after grant is treated as a new byte.
  - req dropped before grant: no effect.
  - req/req_data changes after grant do not affect the byte in flight.
- tx_busy already high while in IDLE (a foreign frame): arbiter still launches. LAUNCH sees busy and moves to SEND; done fires when that busy ends.
- Only one grant and one done bit is ever high per cycle.
- rr_ptr wrap: winner N_REQ-1 gives rr_ptr=0.
- Unused req bits: none (N_REQ sets width exactly).

Optional Feature:
- Macro UART_TX_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority; lowest set req index always wins. rr_ptr removed, or tied to 0 and never updated.
  - Undefined: round-robin as above.
- All other timing identical.

Test Plan:
- Single request: N_REQ=4, req=4'b0100, req_data[2]=8'hA5; model asserts tx_busy 2 cycles after tx_start for 20 cycles.
  -> grant=4'b0100 one cycle after req; tx_data=8'hA5; tx_start drops the cycle after tx_busy rises; done=4'b0100 one cycle after tx_busy falls; busy_o returns 0.
- Round-robin fairness: req=4'b1111 held continuously, bytes 8'h10..8'h13.
  -> grant order 0,1,2,3,0; tx_data sequence 10,11,12,13,10.
  -> With the macro defined: grant always 4'b0001.
- Pointer wrap: serve requester 3 alone, then req=4'b1001.
  -> next grant=4'b0001; then 4'b1000.
- Timeout: TIMEOUT=16, req=4'b0010, tx_busy tied 0.
  -> tx_start high exactly 16 cycles; err_timeout pulses once; no done; next grant goes to index 2 or above if requested.
- Reset mid-operation: rst=0 for one edge while in SEND.
  -> all outputs 0 after that edge; no done; rr_ptr=0; the following req=4'b0011 grants index 0.
- Late req change: after grant to index 1, change req_data[1] to 8'hFF.
  -> tx_data keeps the originally latched value until done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter among N_REQ requesters.
// A round-robin arbiter picks a requester in IDLE. It latches that requester's
// byte and launches the transmitter. It follows tx_busy through the frame and
// then pulses done to the owner.
//
// Optional build macro: UART_TX_ARB_FIXED_PRIO_EN selects fixed priority
// (the lowest set index always wins) instead of round-robin.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   req          per-requester byte-pending request (level)
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   grant        one-hot 1-cycle pulse: byte accepted and latched
//   done         one-hot 1-cycle pulse: byte fully transmitted
//   tx_data      latched byte to the transmitter
//   tx_start     launch request to the transmitter (level)
//   tx_busy      transmitter frame in progress
//   active_id    index of the current owner (valid while busy_o=1)
//   busy_o       arbiter not in IDLE
//   err_timeout  1-cycle pulse: the transmitter never went busy after launch
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         active_id,
  output logic                    busy_o,
  output logic                    err_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [N_REQ-1:0]   rot;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic [DATA_W-1:0]  win_data;

  // Next index after id, wrapping at N_REQ.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // With fixed priority the scan always starts at index 0.
  assign rr_ptr = '0;
`endif

  // Rotate req so that bit 0 is the rr_ptr slot, then take the first set bit.
  always_comb begin
    rot    = N_REQ'({req, req} >> rr_ptr);
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        winner = ID_W'((k + 32'(rr_ptr)) % N_REQ);
      end
    end
  end

  // Byte of the selected requester.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= '0;
      done        <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      active_id   <= '0;
      busy_o      <= 1'b0;
      err_timeout <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      grant       <= '0;
      done        <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data   <= win_data;
            active_id <= winner;
            grant     <= N_REQ'(1) << winner;
            tx_start  <= 1'b1;
            busy_o    <= 1'b1;
            cnt       <= '0;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          // tx_busy takes precedence over the timeout on the same edge.
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= SEND;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b1;
            busy_o      <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr      <= next_id(active_id);
`endif
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND: begin
          if (!tx_busy) begin
            done   <= N_REQ'(1) << active_id;
            busy_o <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr <= next_id(active_id);
`endif
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [IW-1:0]   active_id;
  logic            busy_o;
  logic            err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .active_id(active_id), .busy_o(busy_o),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester that should win, given the request pattern and pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int base;
    int idx;
    base = p;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    base = 0;
`endif
    for (int k = 0; k < int'(N); k++) begin
      idx = (base + k) % int'(N);
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic int after(input int w);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (w + 1) % int'(N);
`endif
  endfunction

  // One full transaction: request, grant, launch, frame (or timeout/reset).
  task automatic txn(input logic [N-1:0] r, input logic [N*DW-1:0] d, input int dly,
                     input int len, input bit tmo, input bit foreign, input bit do_rst);
    int w;
    logic [DW-1:0] exp_d;
    w     = pick(r, ptr);
    exp_d = DW'(d >> (DW * w));
    req = r; req_data = d; tx_busy = foreign;
    tick();
    check("grant", 32'(grant), 32'(1) << w);
    check("tx_start_rise", 32'(tx_start), 32'd1);
    check("tx_data_latch", 32'(tx_data), 32'(exp_d));
    check("active_id", 32'(active_id), 32'(w));
    check("busy_o_set", 32'(busy_o), 32'd1);
    // Drop the request and scramble the data: the byte in flight must not change.
    req = '0; req_data = N*DW'($urandom);
    if (tmo) begin
      tx_busy = 1'b0;
      for (int i = 0; i < int'(TO) - 1; i++) begin
        tick();
        check("tmo_start_held", 32'(tx_start), 32'd1);
        check("tmo_no_err_yet", 32'(err_timeout), 32'd0);
      end
      tick();
      check("tmo_start_drop", 32'(tx_start), 32'd0);
      check("tmo_err", 32'(err_timeout), 32'd1);
      check("tmo_no_done", 32'(done), 32'd0);
      check("tmo_busy_o", 32'(busy_o), 32'd0);
      ptr = after(w);
      tick();
      check("tmo_err_once", 32'(err_timeout), 32'd0);
      check("tmo_idle_no_grant", 32'(grant), 32'd0);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      check("launch_start_held", 32'(tx_start), 32'd1);
    end
    tx_busy = 1'b1;
    tick();
    check("start_drop", 32'(tx_start), 32'd0);
    check("send_busy_o", 32'(busy_o), 32'd1);
    for (int i = 0; i < len; i++) begin
      tick();
      check("send_no_done", 32'(done), 32'd0);
      check("send_data_hold", 32'(tx_data), 32'(exp_d));
      check("send_no_grant", 32'(grant), 32'd0);
    end
    if (do_rst) begin
      rst = 1'b0;
      tick();
      rst = 1'b1; tx_busy = 1'b0;
      check("rst_outputs", 32'({grant, done, tx_data, tx_start, active_id, busy_o, err_timeout}), 32'd0);
      ptr = 0;
      tick();
      check("rst_no_done", 32'(done), 32'd0);
      check("rst_idle", 32'(busy_o), 32'd0);
      return;
    end
    tx_busy = 1'b0;
    tick();
    check("done", 32'(done), 32'(1) << w);
    check("done_busy_o", 32'(busy_o), 32'd0);
    check("done_no_err", 32'(err_timeout), 32'd0);
    ptr = after(w);
  endtask

  initial begin
    logic [N-1:0]    r;
    logic [N*DW-1:0] d;
    bit tmo, foreign;
    int dly;

    // Reset state.
    rst = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'({grant, done, tx_data, tx_start, active_id, busy_o, err_timeout}), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_no_grant", 32'(grant), 32'd0);
    check("idle_busy_o", 32'(busy_o), 32'd0);

    // Single request, byte A5 on requester 2.
    txn(4'b0100, 32'h00A5_0000, 1, 20, 1'b0, 1'b0, 1'b0);

    // Reset back to a known pointer, then fairness with all four requesting.
    rst = 1'b0; tick(); rst = 1'b1; ptr = 0;
    for (int i = 0; i < 5; i++) txn(4'b1111, 32'h1312_1110, 0, 2, 1'b0, 1'b0, 1'b0);

    // Pointer wrap: requester 3 alone, then 3 and 0 together.
    txn(4'b1000, 32'h7700_0000, 2, 3, 1'b0, 1'b0, 1'b0);
    txn(4'b1001, 32'h6600_0055, 0, 1, 1'b0, 1'b0, 1'b0);
    txn(4'b1001, 32'h6600_0055, 0, 1, 1'b0, 1'b0, 1'b0);

    // Timeout on requester 1, then everyone requests.
    txn(4'b0010, 32'h0000_3C00, 0, 0, 1'b1, 1'b0, 1'b0);
    txn(4'b1111, 32'hD4C3_B2A1, 0, 2, 1'b0, 1'b0, 1'b0);

    // Foreign frame already active at launch.
    txn(4'b0101, 32'h0099_0088, 0, 4, 1'b0, 1'b1, 1'b0);

    // Reset while in SEND, then 0011 must grant index 0.
    txn(4'b0110, 32'h0044_3300, 1, 2, 1'b0, 1'b0, 1'b1);
    txn(4'b0011, 32'h0000_2211, 0, 1, 1'b0, 1'b0, 1'b0);

    // Late data change on requester 1 (scrambled inside txn after grant).
    txn(4'b0010, 32'h0000_5A00, 3, 5, 1'b0, 1'b0, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      r       = N'($urandom_range(1, 15));
      d       = N*DW'($urandom);
      tmo     = ($urandom_range(0, 7) == 0);
      foreign = !tmo && ($urandom_range(0, 7) == 0);
      dly     = foreign ? 0 : int'($urandom_range(0, 8));
      txn(r, d, dly, int'($urandom_range(1, 6)), tmo, foreign, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
